// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the stack word sequencer.
package cpu_pkg;

   localparam logic [7:0] SP_RESET_DEFAULT = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PUSH_LO = 3'd1,
      ST_PUSH_HI = 3'd2,
      ST_POP_HI  = 3'd3,
      ST_POP_LO  = 3'd4,
      ST_DONE    = 3'd5
   } stack_state_t;

   // True for the states that drive a RAM access.
   function automatic logic is_ram_state(input stack_state_t s);
      return (s == ST_PUSH_LO) || (s == ST_PUSH_HI) ||
             (s == ST_POP_HI)  || (s == ST_POP_LO);
   endfunction

   // True for the states that write RAM.
   function automatic logic is_write_state(input stack_state_t s);
      return (s == ST_PUSH_LO) || (s == ST_PUSH_HI);
   endfunction

endpackage

// File: rtl/stack_word_seq.sv
// Moves a 16-bit word to/from the 8-bit internal RAM as two byte accesses
// while maintaining the stack pointer (8051 ordering: low byte at the lower
// address, SP pre-incremented on push, post-decremented on pop).
// All outputs are registered; their next values are decoded from the next
// state so they line up with the state they describe.
module stack_word_seq
   import cpu_pkg::*;
#(
   parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_req,
   input  logic        pop_req,
   input  logic [15:0] push_word,
   input  logic        sp_load,
   input  logic [7:0]  sp_value,
   output logic [7:0]  sp,
   output logic        busy,
   output logic        done,
   output logic [15:0] pop_word,
   output logic        ram_req,
   output logic        ram_we,
   output logic [7:0]  ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   input  logic        ram_ack
);

   stack_state_t state_q, state_d;
   logic [7:0]   sp_q, sp_d;
   logic [15:0]  word_q, word_d;
   logic [15:0]  pop_word_q, pop_word_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         ram_req_q, ram_req_d;
   logic         ram_we_q, ram_we_d;
   logic [7:0]   ram_addr_q, ram_addr_d;
   logic [7:0]   ram_wdata_q, ram_wdata_d;
   logic         xfer_ack_s;

   // A byte access completes when our request meets the RAM acknowledge.
   assign xfer_ack_s = ram_req_q & ram_ack;

   // Next state, stack pointer and data-word updates.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      word_d     = word_q;
      pop_word_d = pop_word_q;
      case (state_q)
         ST_IDLE: begin
            if (sp_load) begin
               sp_d = sp_value;
            end else if (push_req) begin
               state_d = ST_PUSH_LO;
               word_d  = push_word;
            end else if (pop_req) begin
               state_d = ST_POP_HI;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PUSH_LO: begin
            if (xfer_ack_s) begin
               sp_d    = sp_q + 8'd1;
               state_d = ST_PUSH_HI;
            end else begin
               state_d = ST_PUSH_LO;
            end
         end
         ST_PUSH_HI: begin
            if (xfer_ack_s) begin
               sp_d    = sp_q + 8'd1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_PUSH_HI;
            end
         end
         ST_POP_HI: begin
            if (xfer_ack_s) begin
               pop_word_d[15:8] = ram_rdata;
               sp_d             = sp_q - 8'd1;
               state_d          = ST_POP_LO;
            end else begin
               state_d = ST_POP_HI;
            end
         end
         ST_POP_LO: begin
            if (xfer_ack_s) begin
               pop_word_d[7:0] = ram_rdata;
               sp_d            = sp_q - 8'd1;
               state_d         = ST_DONE;
            end else begin
               state_d = ST_POP_LO;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state; a stalled access reproduces itself.
   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      ram_req_d   = is_ram_state(state_d);
      ram_we_d    = is_write_state(state_d);
      ram_addr_d  = 8'h00;
      ram_wdata_d = 8'h00;
      case (state_d)
         ST_PUSH_LO: begin
            ram_addr_d  = sp_d + 8'd1;
            ram_wdata_d = word_d[7:0];
         end
         ST_PUSH_HI: begin
            ram_addr_d  = sp_d + 8'd1;
            ram_wdata_d = word_d[15:8];
         end
         ST_POP_HI, ST_POP_LO: begin
            ram_addr_d = sp_d;
         end
         default: begin
            ram_addr_d  = 8'h00;
            ram_wdata_d = 8'h00;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sp_q        <= SP_RESET;
         word_q      <= 16'h0000;
         pop_word_q  <= 16'h0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= 8'h00;
         ram_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         word_q      <= word_d;
         pop_word_q  <= pop_word_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign sp        = sp_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pop_word  = pop_word_q;
   assign ram_req   = ram_req_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule
